// File: rtl/symm_orth_iter.sv
// symm_orth_iter
//   Iteration controller for the 4x4 symmetric-orthogonalization engine.
//   The matrix W is loaded element-serially (row-major). Each iteration
//   issues the external engine for one cycle (it registers (W*W^T*W)>>>1
//   on en_mul3), then applies W_next = W + (W>>>1) - m in the following
//   cycle. Iteration stops when every element moved by less than TOL or
//   after MAX_ITER iterations. The result is then streamed out row-major.
//
// Ports
//   clk_orth, rst_orth     : clock (rising edge), async active-high reset
//   in_valid/in_ready/in_data    : load stream, signed Q12.13 elements
//   out_valid/out_ready/out_data : drain stream, signed Q12.13 elements
//   w_flat  : current W to engine, element (r,c) at [(4r+c)*26 +: 26]
//   en_mul3 : engine enable (high only in ISSUE)
//   m_flat  : engine result, same packing as w_flat
//   busy    : first load accept until done
//   done    : one-cycle pulse after the last drain handshake
//   converged, iter_count : status of the last/current matrix
module symm_orth_iter #(
    parameter int MAX_ITER = 32,
    parameter int TOL      = 8,
    parameter int ITER_W   = 6
) (
    input  logic              clk_orth,
    input  logic              rst_orth,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [25:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [25:0]       out_data,
    output logic [415:0]      w_flat,
    output logic              en_mul3,
    input  logic [415:0]      m_flat,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic [ITER_W-1:0] iter_count
);

    localparam int DATA_W = 26;
    localparam int N_EL   = 16;
    localparam logic [DATA_W:0]   TOL_L = (DATA_W + 1)'(TOL);
    localparam logic [ITER_W-1:0] MAX_L = ITER_W'(MAX_ITER);

    typedef enum logic [1:0] {LOAD, ISSUE, UPDATE, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               elem_q, elem_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     conv_q, conv_d;
    logic [ITER_W-1:0]        iter_q, iter_d;
    logic signed [DATA_W-1:0] w_q [N_EL];
    logic signed [DATA_W-1:0] wn  [N_EL];
    logic                     all_pass;
    logic                     load_we, upd_we;

    // 26-bit wrap on purpose: matches the engine's two's-complement behaviour.
    function automatic logic signed [DATA_W-1:0] next_elem(
        input logic signed [DATA_W-1:0] w,
        input logic signed [DATA_W-1:0] m
    );
        return w + (w >>> 1) - m;
    endfunction

    function automatic logic signed [DATA_W:0] delta_of(
        input logic signed [DATA_W-1:0] w_new,
        input logic signed [DATA_W-1:0] w_old
    );
        return {w_new[DATA_W-1], w_new} - {w_old[DATA_W-1], w_old};
    endfunction

    // |d| for a 27-bit value; the single unrepresentable case saturates.
    function automatic logic [DATA_W:0] abs_sat(input logic signed [DATA_W:0] d);
        if (d == {1'b1, {DATA_W{1'b0}}})
            return {1'b0, {DATA_W{1'b1}}};
        else if (d[DATA_W])
            return -d;
        else
            return d;
    endfunction

    always_comb begin
        all_pass = 1'b1;
        for (int i = 0; i < N_EL; i++) begin
            wn[i] = next_elem(w_q[i], $signed(m_flat[i*DATA_W +: DATA_W]));
            if (abs_sat(delta_of(wn[i], w_q[i])) >= TOL_L)
                all_pass = 1'b0;
        end
    end

    always_comb begin
        w_flat = '0;
        for (int i = 0; i < N_EL; i++)
            w_flat[i*DATA_W +: DATA_W] = w_q[i];
    end

    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        conv_d    = conv_q;
        iter_d    = iter_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        en_mul3   = 1'b0;
        load_we   = 1'b0;
        upd_we    = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_we = 1'b1;
                    elem_d  = elem_q + 4'd1;
                    // busy low here means this is the first element of a new matrix
                    if (!busy_q) begin
                        busy_d = 1'b1;
                        conv_d = 1'b0;
                        iter_d = '0;
                    end
                    if (elem_q == 4'd15) begin
                        state_d = ISSUE;
                        elem_d  = '0;
                    end
                end
            end
            ISSUE: begin
                en_mul3 = 1'b1;
                state_d = UPDATE;
            end
            UPDATE: begin
                upd_we = 1'b1;
                iter_d = iter_q + 1'b1;
                if (all_pass) begin
                    conv_d  = 1'b1;
                    state_d = DRAIN;
                end else if (iter_q + 1'b1 == MAX_L) begin
                    conv_d  = 1'b0;
                    state_d = DRAIN;
                end else begin
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    elem_d = elem_q + 4'd1;
                    if (elem_q == 4'd15) begin
                        state_d = LOAD;
                        elem_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk_orth or posedge rst_orth) begin
        if (rst_orth) begin
            state_q <= LOAD;
            elem_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            conv_q  <= 1'b0;
            iter_q  <= '0;
            for (int i = 0; i < N_EL; i++)
                w_q[i] <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            conv_q  <= conv_d;
            iter_q  <= iter_d;
            if (load_we)
                w_q[elem_q] <= $signed(in_data);
            else if (upd_we)
                for (int i = 0; i < N_EL; i++)
                    w_q[i] <= wn[i];
        end
    end

    assign out_data   = w_q[elem_q];
    assign busy       = busy_q;
    assign done       = done_q;
    assign converged  = conv_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_symm_orth_iter.sv
module tb_symm_orth_iter;

    localparam int MAX_ITER = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;        // 0: TOL=8 instance, 1: TOL=0 instance
    logic        in_valid = 1'b0;
    logic [25:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, en_a, busy_a, done_a, conv_a;
    logic        in_ready_b, out_valid_b, en_b, busy_b, done_b, conv_b;
    logic [25:0] out_data_a, out_data_b;
    logic [415:0] w_a, w_b, m_a, m_b;
    logic [5:0]  iter_a, iter_b;

    logic        in_ready, out_valid, en_mul3, busy, done, converged;
    logic [25:0] out_data;
    logic [415:0] w_flat;
    logic [5:0]  iter_count;

    symm_orth_iter #(.MAX_ITER(MAX_ITER), .TOL(8), .ITER_W(6)) dut_a (
        .clk_orth(clk), .rst_orth(rst),
        .in_valid(in_valid & ~sel), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready & ~sel), .out_data(out_data_a),
        .w_flat(w_a), .en_mul3(en_a), .m_flat(m_a),
        .busy(busy_a), .done(done_a), .converged(conv_a), .iter_count(iter_a)
    );

    symm_orth_iter #(.MAX_ITER(MAX_ITER), .TOL(0), .ITER_W(6)) dut_b (
        .clk_orth(clk), .rst_orth(rst),
        .in_valid(in_valid & sel), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready & sel), .out_data(out_data_b),
        .w_flat(w_b), .en_mul3(en_b), .m_flat(m_b),
        .busy(busy_b), .done(done_b), .converged(conv_b), .iter_count(iter_b)
    );

    assign in_ready   = sel ? in_ready_b  : in_ready_a;
    assign out_valid  = sel ? out_valid_b : out_valid_a;
    assign out_data   = sel ? out_data_b  : out_data_a;
    assign en_mul3    = sel ? en_b        : en_a;
    assign busy       = sel ? busy_b      : busy_a;
    assign done       = sel ? done_b      : done_a;
    assign converged  = sel ? conv_b      : conv_a;
    assign iter_count = sel ? iter_b      : iter_a;
    assign w_flat     = sel ? w_b         : w_a;

    // Triple-product engine: Q12.13 matrix products, result halved, 26-bit wrap.
    function automatic logic [415:0] engine(input logic [415:0] wf);
        longint w[16];
        longint p[16];
        longint s;
        logic [63:0] q;
        logic [415:0] r;
        for (int i = 0; i < 16; i++) w[i] = longint'($signed(wf[i*26 +: 26]));
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += w[4*a+k] * w[4*b+k];
                p[4*a+b] = s >>> 13;
            end
        r = '0;
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += p[4*a+k] * w[4*k+b];
                q = 64'((s >>> 13) >>> 1);
                r[(4*a+b)*26 +: 26] = q[25:0];
            end
        return r;
    endfunction

    always @(posedge clk) begin
        if (en_a) m_a <= engine(w_a);
        if (en_b) m_b <= engine(w_b);
    end

    int en_cnt = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (en_mul3) en_cnt++;
        if (done) done_cnt++;
    end

    int checks = 0;
    int errors = 0;
    int en0 = 0;

    logic [25:0] g_res [16];
    int          g_iters;
    bit          g_conv;

    function automatic longint wrap26(input longint x);
        logic [63:0] v;
        v = 64'(x);
        return longint'($signed(v[25:0]));
    endfunction

    // Reference: iterate the update rule on whole matrices until all deltas are small.
    task automatic golden(input longint w0[16], input int tol);
        longint w[16];
        logic [415:0] wf, mf;
        longint m, wn, d;
        bit conv;
        logic [63:0] t;
        w = w0;
        g_iters = 0;
        conv = 1'b0;
        while (!conv && g_iters < MAX_ITER) begin
            for (int i = 0; i < 16; i++) begin
                t = 64'(w[i]);
                wf[i*26 +: 26] = t[25:0];
            end
            mf = engine(wf);
            conv = 1'b1;
            for (int i = 0; i < 16; i++) begin
                m  = longint'($signed(mf[i*26 +: 26]));
                wn = wrap26(w[i] + (w[i] >>> 1) - m);
                d  = wn - w[i];
                if (d < 0) d = -d;
                if (d >= tol) conv = 1'b0;
                w[i] = wn;
            end
            g_iters++;
        end
        g_conv = conv;
        for (int i = 0; i < 16; i++) begin
            t = 64'(w[i]);
            g_res[i] = t[25:0];
        end
    endtask

    task automatic load(input longint w[16], input bit gaps);
        int cnt;
        logic [63:0] t;
        for (int e = 0; e < 16; e++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
            t = 64'(w[e]);
            in_valid = 1'b1;
            in_data  = t[25:0];
            cnt = 0;
            while (!in_ready && cnt < 100) begin
                @(negedge clk);
                cnt++;
            end
            checks++;
            if (!in_ready) begin
                errors++;
                $display("FAIL load_ready elem %0d: in_ready=%b required 1", e, in_ready);
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
            if (e == 0) begin
                checks++;
                if (busy !== 1'b1 || converged !== 1'b0 || iter_count !== 6'd0) begin
                    errors++;
                    $display("FAIL first_accept: busy=%b conv=%b iter=%0d required 1 0 0",
                             busy, converged, iter_count);
                end
            end
        end
        en0 = en_cnt;
    endtask

    task automatic drain(input int n, input bit stall, input bit chk_lat);
        int cnt;
        int d0;
        d0 = done_cnt;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1 && chk_lat) begin
                checks++;
                if (en_mul3 !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL issue_cycle: en_mul3=%b busy=%b required 1 1", en_mul3, busy);
                end
            end
        end while (!out_valid && cnt < 200);
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL drain_timeout: out_valid=%b after %0d cycles", out_valid, cnt);
            return;
        end
        if (chk_lat) begin
            checks++;
            if (cnt != 2 * g_iters + 1) begin
                errors++;
                $display("FAIL latency: first out_valid at cycle %0d required %0d", cnt, 2 * g_iters + 1);
            end
        end
        for (int e = 0; e < n; e++) begin
            if (stall) begin
                repeat ($urandom_range(0, 2)) begin
                    out_ready = 1'b0;
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== g_res[e]) begin
                        errors++;
                        $display("FAIL stall_hold elem %0d: valid=%b data=%0h required 1 %0h",
                                 e, out_valid, out_data, g_res[e]);
                    end
                    @(negedge clk);
                end
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== g_res[e]) begin
                errors++;
                $display("FAIL out_data elem %0d: valid=%b data=%0h required 1 %0h",
                         e, out_valid, out_data, g_res[e]);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
        end
        if (n == 16) begin
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL done_pulse: done=%b busy=%b out_valid=%b in_ready=%b required 1 0 0 1",
                         done, busy, out_valid, in_ready);
            end
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || done_cnt - d0 != 1) begin
                errors++;
                $display("FAIL done_once: done=%b pulses=%0d required 0 1", done, done_cnt - d0);
            end
            checks++;
            if (converged !== g_conv || iter_count !== 6'(g_iters)) begin
                errors++;
                $display("FAIL status: conv=%b iter=%0d required %b %0d",
                         converged, iter_count, g_conv, g_iters);
            end
            checks++;
            if (en_cnt - en0 != g_iters) begin
                errors++;
                $display("FAIL en_mul3_count: %0d cycles required %0d", en_cnt - en0, g_iters);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic void make_diag(output longint w[16], input longint dv);
        for (int i = 0; i < 16; i++) w[i] = (i % 5 == 0) ? dv : 0;
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || en_mul3 !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || converged !== 1'b0 || iter_count !== 6'd0 || w_flat !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b ov=%b en=%b busy=%b done=%b conv=%b iter=%0d wz=%b",
                     in_ready, out_valid, en_mul3, busy, done, converged, iter_count, w_flat == '0);
        end
        do_reset();
    endtask

    task automatic test_identity();
        longint w[16];
        make_diag(w, 8192);
        golden(w, 8);
        load(w, 1'b0);
        drain(16, 1'b0, 1'b1);
        checks++;
        if (converged !== 1'b1 || iter_count !== 6'd1) begin
            errors++;
            $display("FAIL identity_status: conv=%b iter=%0d required 1 1", converged, iter_count);
        end
    endtask

    task automatic test_half_identity();
        longint w[16];
        make_diag(w, 4096);
        golden(w, 8);
        load(w, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (w_flat[25:0] !== 26'd5632 || w_flat[51:26] !== 26'd0) begin
            errors++;
            $display("FAIL half_first_update: w00=%0d w01=%0d required 5632 0",
                     w_flat[25:0], w_flat[51:26]);
        end
        drain(16, 1'b0, 1'b0);
        checks++;
        if (converged !== 1'b1 || g_res[0] < 26'd8185 || g_res[0] > 26'd8199) begin
            errors++;
            $display("FAIL half_converged: conv=%b diag=%0d required 1 near 8192", converged, g_res[0]);
        end
    endtask

    task automatic test_zero();
        longint w[16];
        make_diag(w, 0);
        golden(w, 8);
        load(w, 1'b0);
        drain(16, 1'b0, 1'b1);
        checks++;
        if (converged !== 1'b1 || iter_count !== 6'd1) begin
            errors++;
            $display("FAIL zero_status: conv=%b iter=%0d required 1 1", converged, iter_count);
        end
    endtask

    task automatic test_tol0();
        longint w[16];
        sel = 1'b1;
        make_diag(w, 4096);
        golden(w, 0);
        load(w, 1'b0);
        drain(16, 1'b1, 1'b1);
        checks++;
        if (converged !== 1'b0 || iter_count !== 6'd32 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tol0_exit: conv=%b iter=%0d busy=%b required 0 32 0",
                     converged, iter_count, busy);
        end
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        longint w[16];
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 16; i++)
                w[i] = longint'($urandom_range(0, 16383)) - 8192 + ((i % 5 == 0) ? 4096 : 0);
            golden(w, 8);
            load(w, n[0]);
            drain(16, 1'b1, ~n[0]);
        end
    endtask

    task automatic test_reset_mid();
        longint w[16];
        make_diag(w, 4096);
        load(w, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (en_mul3 !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_issue: en=%b busy=%b ov=%b rdy=%b required 0 0 0 1",
                     en_mul3, busy, out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) w[i] = longint'($urandom_range(0, 8191)) - 4096;
        golden(w, 8);
        load(w, 1'b0);
        drain(7, 1'b0, 1'b1);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || iter_count !== 6'd0) begin
            errors++;
            $display("FAIL reset_drain: ov=%b busy=%b iter=%0d required 0 0 0",
                     out_valid, busy, iter_count);
        end
        @(negedge clk);
        rst = 1'b0;
        make_diag(w, 6144);
        golden(w, 8);
        load(w, 1'b1);
        drain(16, 1'b1, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_identity();
        test_half_identity();
        test_zero();
        test_tol0();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
